// File: rtl/lin_seq_ctrl_if.sv
// Purpose : bundle of handshake and array-drive signals for lin_seq_ctrl.
// Ports   : cfg_* weight load, start/len job launch, act_* activation stream,
//           pe_* linear-array drive and results, res_* result handshake,
//           busy/done status. The master modport is the environment side,
//           the slave modport is the sequencer side.
interface lin_seq_ctrl_if #(
  parameter int NPE = 4,
  parameter int AW  = 8,
  parameter int OW  = 12
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [AW-1:0]            cfg_w;
  logic                     start;
  logic [7:0]               len;
  logic                     act_valid;
  logic                     act_ready;
  logic [AW-1:0]            act_data;
  logic [NPE-1:0][AW-1:0]   pe_w;
  logic [AW-1:0]            pe_a;
  logic                     pe_fire;
  logic [NPE-1:0][OW-1:0]   pe_outs;
  logic                     res_valid;
  logic                     res_ready;
  logic [NPE-1:0][OW-1:0]   res_data;
  logic                     busy;
  logic                     done;

  modport master (
    output cfg_valid, cfg_w, start, len, act_valid, act_data, pe_outs, res_ready,
    input  cfg_ready, act_ready, pe_w, pe_a, pe_fire, res_valid, res_data, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_w, start, len, act_valid, act_data, pe_outs, res_ready,
    output cfg_ready, act_ready, pe_w, pe_a, pe_fire, res_valid, res_data, busy, done
  );
endinterface

// File: rtl/lin_seq_ctrl.sv
// Purpose : sequencer for a linear array of NPE processing elements. Loads
//           one weight per PE, streams len activations into the array,
//           flushes it for DRAIN_CYC cycles, then presents the captured
//           array outputs through a valid/ready result handshake.
// Ports   : clk  - single clock, all state on posedge
//           rst  - asynchronous active-high reset
//           bus  - lin_seq_ctrl_if.slave (cfg, start/len, act, pe, res, status)
module lin_seq_ctrl #(
  parameter int NPE       = 4,
  parameter int AW        = 8,
  parameter int OW        = 12,
  parameter int DRAIN_CYC = NPE
) (
  input logic           clk,
  input logic           rst,
  lin_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam int IDXW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int DCW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NPE - 1);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC);

  logic [1:0]               r_state;
  logic [IDXW-1:0]          r_idx;
  logic [NPE-1:0][AW-1:0]   r_pe_w;
  logic [7:0]               r_len;
  logic [7:0]               r_cnt;
  logic [DCW-1:0]           r_dcnt;
  logic [AW-1:0]            r_pe_a;
  logic                     r_pe_fire;
  logic                     r_res_valid;
  logic [NPE-1:0][OW-1:0]   r_res_data;
  logic                     r_done;
  logic                     r_busy;
  logic                     r_act_ready;
  logic                     r_cfg_ready;

  logic                     w_cfg_beat;
  logic                     w_act_beat;
  logic [7:0]               w_cnt_nxt;
  logic                     w_last_act;

  // Handshake qualifiers; the count never exceeds len-1 before the increment,
  // so the 8-bit sum cannot wrap even for len=255.
  assign w_cfg_beat = bus.cfg_valid & r_cfg_ready;
  assign w_act_beat = bus.act_valid & r_act_ready;
  assign w_cnt_nxt  = r_cnt + 8'd1;
  assign w_last_act = (w_cnt_nxt == r_len);

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.act_ready = r_act_ready;
  assign bus.pe_w      = r_pe_w;
  assign bus.pe_a      = r_pe_a;
  assign bus.pe_fire   = r_pe_fire;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Job sequencer: state, counters and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pe_w      <= '0;
      r_len       <= 8'd0;
      r_cnt       <= 8'd0;
      r_dcnt      <= '0;
      r_pe_a      <= '0;
      r_pe_fire   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_act_ready <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pe_a    <= '0;
          r_pe_fire <= 1'b0;
          // A weight beat and a start in the same cycle both land; the job
          // therefore sees the freshly written weight.
          if (w_cfg_beat) begin
            r_pe_w[r_idx] <= bus.cfg_w;
            if (r_idx == IDX_LAST) begin
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          if (bus.start && (bus.len != 8'd0)) begin
            r_state     <= S_STREAM;
            r_len       <= bus.len;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b1;
            r_act_ready <= 1'b1;
            r_cfg_ready <= 1'b0;
          end else if (bus.start) begin
            // Empty job: completes immediately without touching the array.
            r_done <= 1'b1;
          end else begin
            r_cfg_ready <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_act_beat) begin
            r_pe_a    <= bus.act_data;
            r_pe_fire <= 1'b1;
            r_cnt     <= w_cnt_nxt;
            if (w_last_act) begin
              r_state     <= S_DRAIN;
              r_act_ready <= 1'b0;
              r_dcnt      <= '0;
            end else begin
              r_act_ready <= 1'b1;
            end
          end else begin
            r_pe_a    <= '0;
            r_pe_fire <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The edge after the last flush cycle captures the array outputs.
          if (r_dcnt == DRAIN_LAST) begin
            r_state     <= S_RESULT;
            r_pe_a      <= '0;
            r_pe_fire   <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_data  <= bus.pe_outs;
          end else begin
            r_dcnt    <= r_dcnt + 1'b1;
            r_pe_a    <= '0;
            r_pe_fire <= 1'b1;
          end
        end
        S_RESULT: begin
          r_pe_a    <= '0;
          r_pe_fire <= 1'b0;
          if (bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else begin
            r_res_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_pe_a      <= '0;
          r_pe_fire   <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_act_ready <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lin_seq_ctrl.sv
module tb_lin_seq_ctrl;
  localparam int NPE = 4;
  localparam int AW  = 8;
  localparam int OW  = 12;
  localparam int DRN = NPE;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [AW-1:0] m_w [NPE];
  int            m_idx;

  lin_seq_ctrl_if #(.NPE(NPE), .AW(AW), .OW(OW)) bus ();

  lin_seq_ctrl #(.NPE(NPE), .AW(AW), .OW(OW), .DRAIN_CYC(DRN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NPE*AW-1:0] exp_pew();
    logic [NPE*AW-1:0] v;
    v = '0;
    for (int i = 0; i < NPE; i++) v[i*AW +: AW] = m_w[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pe_w"},      64'(bus.pe_w), 64'd0);
    chk({tag, "_pe_a"},      64'(bus.pe_a), 64'd0);
    chk({tag, "_pe_fire"},   64'(bus.pe_fire), 64'd0);
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_res_data"},  64'(bus.res_data), 64'd0);
    chk({tag, "_done"},      64'(bus.done), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_act_ready"}, 64'(bus.act_ready), 64'd0);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
  endtask

  task automatic cfg_beat(input logic [AW-1:0] w);
    bus.cfg_valid = 1'b1;
    bus.cfg_w     = w;
    tick();
    bus.cfg_valid = 1'b0;
    m_w[m_idx] = w;
    m_idx = (m_idx + 1) % NPE;
    chk("load_pe_w", 64'(bus.pe_w), 64'(exp_pew()));
    chk("load_cfg_ready", 64'(bus.cfg_ready), 64'd1);
  endtask

  // One complete job. vmask/nfix force the first act_valid values, dstart>0
  // gives accepted beats the data dstart, dstart+1, ...; afterwards act_valid
  // is random with bub_pct percent bubbles. rdly is the res_ready stall.
  task automatic run_job(input int n, input logic [31:0] vmask, input int nfix,
                         input int dstart, input int bub_pct, input int rdly,
                         input bit with_cfg, input logic [AW-1:0] cfg_val);
    int acc;
    int k;
    bit v;
    logic [AW-1:0] d;
    logic [NPE*OW-1:0] exp_res;

    bus.start     = 1'b1;
    bus.len       = 8'(n);
    bus.cfg_valid = with_cfg;
    bus.cfg_w     = cfg_val;
    tick();
    bus.cfg_valid = 1'b0;
    if (with_cfg) begin
      m_w[m_idx] = cfg_val;
      m_idx = (m_idx + 1) % NPE;
    end
    // keep start high while busy: it must have no effect
    bus.len = 8'd5;
    chk("start_busy", 64'(bus.busy), 64'd1);
    chk("start_act_ready", 64'(bus.act_ready), 64'd1);
    chk("start_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("start_fire", 64'(bus.pe_fire), 64'd0);
    chk("start_pe_w", 64'(bus.pe_w), 64'(exp_pew()));

    acc = 0;
    k   = 0;
    while (acc < n) begin
      if (k > 4000) begin
        n_vec++;
        n_err++;
        $error("FAIL stream_timeout: observed %0d accepted, expected %0d", acc, n);
        break;
      end
      v = (k < nfix) ? vmask[k] : ($urandom_range(99) >= bub_pct);
      d = (v && dstart > 0) ? AW'(dstart + acc) : AW'($urandom);
      bus.act_valid = v;
      bus.act_data  = d;
      bus.pe_outs   = (NPE*OW)'({$urandom, $urandom});
      tick();
      if (v) acc++;
      chk("stream_fire", 64'(bus.pe_fire), 64'(v));
      chk("stream_pe_a", 64'(bus.pe_a), v ? 64'(d) : 64'd0);
      chk("stream_act_ready", 64'(bus.act_ready), 64'(acc < n));
      chk("stream_busy", 64'(bus.busy), 64'd1);
      chk("stream_done", 64'(bus.done), 64'd0);
      chk("stream_res_valid", 64'(bus.res_valid), 64'd0);
      k++;
    end
    bus.act_valid = 1'b0;

    for (int j = 0; j < DRN; j++) begin
      bus.pe_outs = (NPE*OW)'({$urandom, $urandom});
      tick();
      chk("drain_fire", 64'(bus.pe_fire), 64'd1);
      chk("drain_pe_a", 64'(bus.pe_a), 64'd0);
      chk("drain_act_ready", 64'(bus.act_ready), 64'd0);
      chk("drain_res_valid", 64'(bus.res_valid), 64'd0);
    end

    bus.start   = 1'b0;
    bus.pe_outs = (NPE*OW)'({$urandom, $urandom});
    exp_res     = bus.pe_outs;
    tick();
    chk("result_valid", 64'(bus.res_valid), 64'd1);
    chk("result_data", 64'(bus.res_data), 64'(exp_res));
    chk("result_fire", 64'(bus.pe_fire), 64'd0);
    chk("result_busy", 64'(bus.busy), 64'd1);

    for (int j = 0; j < rdly; j++) begin
      bus.res_ready = 1'b0;
      bus.pe_outs   = (NPE*OW)'({$urandom, $urandom});
      tick();
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data", 64'(bus.res_data), 64'(exp_res));
      chk("hold_fire", 64'(bus.pe_fire), 64'd0);
      chk("hold_busy", 64'(bus.busy), 64'd1);
      chk("hold_done", 64'(bus.done), 64'd0);
    end

    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("hs_valid", 64'(bus.res_valid), 64'd0);
    chk("hs_done", 64'(bus.done), 64'd1);
    chk("hs_busy", 64'(bus.busy), 64'd0);
    chk("hs_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("hs_pe_w", 64'(bus.pe_w), 64'(exp_pew()));
    tick();
    chk("post_done", 64'(bus.done), 64'd0);
    chk("post_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_idx = 0;
    for (int i = 0; i < NPE; i++) m_w[i] = '0;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_w     = '0;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.pe_outs   = '0;
    bus.res_ready = 1'b0;
    #2;
    chk_reset_vals("rst_init");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("rst_idle");

    // weight load with wrap
    cfg_beat(8'd1);
    cfg_beat(8'd2);
    cfg_beat(8'd3);
    cfg_beat(8'd4);
    cfg_beat(8'd9);

    // back-to-back stream 5,6,7
    run_job(3, 32'b111, 3, 5, 0, 0, 1'b0, 8'd0);
    // bubble pattern 1,0,1
    run_job(2, 32'b101, 3, 0, 0, 0, 1'b0, 8'd0);
    // result backpressure, plus a cfg beat in the start cycle
    run_job(4, 32'b0, 0, 0, 20, 5, 1'b1, 8'hA5);

    // empty job
    bus.start = 1'b1;
    bus.len   = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("len0_done", 64'(bus.done), 64'd1);
    chk("len0_fire", 64'(bus.pe_fire), 64'd0);
    chk("len0_busy", 64'(bus.busy), 64'd0);
    chk("len0_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    tick();
    chk("len0_done_clr", 64'(bus.done), 64'd0);
    chk("len0_fire2", 64'(bus.pe_fire), 64'd0);

    // abort mid-stream after 2 of 5 beats
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.act_valid = 1'b1;
      bus.act_data  = 8'(j + 20);
      tick();
      chk("abort_fire", 64'(bus.pe_fire), 64'd1);
    end
    bus.act_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    tick();
    rst = 1'b0;
    for (int i = 0; i < NPE; i++) m_w[i] = '0;
    m_idx = 0;
    tick();
    chk_reset_vals("rst_after");
    tick();
    chk("rst_no_done", 64'(bus.done), 64'd0);

    cfg_beat(8'd11);
    cfg_beat(8'd12);
    cfg_beat(8'd13);
    cfg_beat(8'd14);
    run_job(3, 32'b0, 0, 0, 30, 1, 1'b0, 8'd0);

    // randomized jobs including the longest length
    for (int r = 0; r < 4; r++) begin
      cfg_beat(AW'($urandom));
      run_job($urandom_range(40, 1), 32'b0, 0, 0, 30, $urandom_range(3), $urandom_range(1), AW'($urandom));
    end
    run_job(255, 32'b0, 0, 0, 25, 2, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
